// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: AXI-lite commanded SPI sequencer driving chip-select, SCLK and byte-engine strobes.
// Optional SPI_MASTER_CTRL_CPOL_EN: wdata[16] selects the SCLK idle level per command.
module spi_master_ctrl #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] axi_lite_awaddr,
    input  logic        axi_lite_awvalid,
    output logic        axi_lite_awready,
    input  logic [31:0] axi_lite_wdata,
    input  logic        axi_lite_wvalid,
    output logic        axi_lite_wready,
    output logic [1:0]  axi_lite_bresp,
    output logic        axi_lite_bvalid,
    input  logic        axi_lite_bready,
    output logic        spi_clk,
    output logic        spi_cs_n,
    output logic        spi_clk_en,
    output logic        spi_clk_recv_int,
    output logic        spi_clk_send_int,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, RESP} state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div_q, div_n, hc_q, hc_n, div_cmd;
    logic [CNT_W:0]   byte_q, byte_n;
    logic [2:0]       bit_q, bit_n;
    logic             sclk_q, sclk_n, csn_q, csn_n;
    logic             recv_q, recv_n, send_q, send_n, en_q, en_n;
    logic [1:0]       bresp_q, bresp_n;
    logic             armed_q;
    logic             accept, expire, cmd_cpol, cpol;
    logic             unused_wdata;

`ifdef SPI_MASTER_CTRL_CPOL_EN
    logic cpol_q, cpol_n;
    assign cpol     = cpol_q;
    assign cmd_cpol = axi_lite_wdata[16];
`else
    assign cpol     = 1'b0;
    assign cmd_cpol = 1'b0;
`endif

    // Only the count and divider fields (and optionally CPOL) carry meaning.
    assign unused_wdata = ^axi_lite_wdata;

    assign div_cmd = (axi_lite_wdata[8 +: DIV_W] == '0) ? DIV_W'(1) : axi_lite_wdata[8 +: DIV_W];
    // armed_q keeps the ready outputs low until the first cycle after reset release.
    assign accept  = (state == IDLE) && armed_q && axi_lite_awvalid && axi_lite_wvalid;
    assign expire  = (hc_q == DIV_W'(1));

    always_comb begin
        state_n = state;
        div_n   = div_q;
        hc_n    = hc_q;
        byte_n  = byte_q;
        bit_n   = bit_q;
        sclk_n  = sclk_q;
        csn_n   = csn_q;
        recv_n  = 1'b0;
        send_n  = 1'b0;
        en_n    = 1'b0;
        bresp_n = bresp_q;
`ifdef SPI_MASTER_CTRL_CPOL_EN
        cpol_n  = cpol_q;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    div_n  = div_cmd;
                    sclk_n = cmd_cpol;
`ifdef SPI_MASTER_CTRL_CPOL_EN
                    cpol_n = cmd_cpol;
`endif
                    if (axi_lite_awaddr != 32'h0) begin
                        state_n = RESP;
                        bresp_n = 2'b10;
                    end else begin
                        state_n = SETUP;
                        csn_n   = 1'b0;
                        hc_n    = div_cmd;
                        byte_n  = (CNT_W+1)'(axi_lite_wdata[CNT_W-1:0]) + (CNT_W+1)'(1);
                        bit_n   = 3'd0;
                        bresp_n = 2'b00;
                        en_n    = (div_cmd == DIV_W'(1));
                    end
                end
            end
            SETUP: begin
                if (expire) begin
                    state_n = XFER;
                    hc_n    = div_q;
                    sclk_n  = ~cpol;
                    recv_n  = 1'b1;
                end else begin
                    hc_n = hc_q - DIV_W'(1);
                    en_n = (hc_q == DIV_W'(2));
                end
            end
            XFER: begin
                if (expire) begin
                    hc_n = div_q;
                    if (sclk_q != cpol) begin
                        // trailing edge: shift point, bit/byte accounting
                        sclk_n = cpol;
                        send_n = 1'b1;
                        bit_n  = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            byte_n = byte_q - (CNT_W+1)'(1);
                            en_n   = (byte_q > (CNT_W+1)'(1));
                        end
                    end else if (byte_q == '0) begin
                        state_n = HOLD;
                    end else begin
                        sclk_n = ~cpol;
                        recv_n = 1'b1;
                    end
                end else begin
                    hc_n = hc_q - DIV_W'(1);
                end
            end
            HOLD: begin
                if (expire) begin
                    state_n = RESP;
                    csn_n   = 1'b1;
                end else begin
                    hc_n = hc_q - DIV_W'(1);
                end
            end
            RESP: begin
                if (axi_lite_bready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            armed_q <= 1'b0;
            div_q   <= DIV_W'(1);
            hc_q    <= '0;
            byte_q  <= '0;
            bit_q   <= 3'd0;
            sclk_q  <= 1'b0;
            csn_q   <= 1'b1;
            recv_q  <= 1'b0;
            send_q  <= 1'b0;
            en_q    <= 1'b0;
            bresp_q <= 2'b00;
`ifdef SPI_MASTER_CTRL_CPOL_EN
            cpol_q  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            armed_q <= 1'b1;
            div_q   <= div_n;
            hc_q    <= hc_n;
            byte_q  <= byte_n;
            bit_q   <= bit_n;
            sclk_q  <= sclk_n;
            csn_q   <= csn_n;
            recv_q  <= recv_n;
            send_q  <= send_n;
            en_q    <= en_n;
            bresp_q <= bresp_n;
`ifdef SPI_MASTER_CTRL_CPOL_EN
            cpol_q  <= cpol_n;
`endif
        end
    end

    assign axi_lite_awready = (state == IDLE) && armed_q;
    assign axi_lite_wready  = (state == IDLE) && armed_q;
    assign axi_lite_bvalid  = (state == RESP);
    assign axi_lite_bresp   = bresp_q;
    assign spi_clk          = sclk_q;
    assign spi_cs_n         = csn_q;
    assign spi_clk_en       = en_q;
    assign spi_clk_recv_int = recv_q;
    assign spi_clk_send_int = send_q;
    assign busy             = (state != IDLE);
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: expected per-command results are queued at drive time
// and compared against monitored SPI activity when the write response handshakes.
module tb_spi_master_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
    logic        awready, wready, bvalid, spi_clk, spi_cs_n, spi_clk_en, recv, send, busy;
    logic [1:0]  bresp;

    spi_master_ctrl dut (
        .clk(clk), .resetn(resetn),
        .axi_lite_awaddr(awaddr), .axi_lite_awvalid(awvalid), .axi_lite_awready(awready),
        .axi_lite_wdata(wdata), .axi_lite_wvalid(wvalid), .axi_lite_wready(wready),
        .axi_lite_bresp(bresp), .axi_lite_bvalid(bvalid), .axi_lite_bready(bready),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_clk_en(spi_clk_en),
        .spi_clk_recv_int(recv), .spi_clk_send_int(send), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bresp, cs_len, nrecv, nsend, nen;
        int rgap, egap_min, egap_max, lat_cs, lat_recv, resp_vs_rise;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_pass = 0;
    localparam int BIG = 1 << 30;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int d, n;
        d = int'(wd[15:8]);
        if (d == 0) d = 1;
        n = int'(wd[7:0]) + 1;
        if (a != 32'h0) begin
            e = '{2, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1};
        end else begin
            e.bresp = 0; e.cs_len = 2*d + 16*d*n;
            e.nrecv = 8*n; e.nsend = 8*n; e.nen = n;
            e.rgap = 2*d;
            e.egap_min = (n >= 2) ? 15*d + 1 : -1;
            e.egap_max = (n >= 3) ? 16*d : e.egap_min;
            e.lat_cs = 1; e.lat_recv = 1 + d; e.resp_vs_rise = 0;
        end
        return e;
    endfunction

    // monitor state, sampled on the falling edge
    int cyc = 0, acc_cyc, cs_len, nrecv, nsend, nen, multi;
    int last_recv, rmin, rmax, last_en, emin, emax, fall_cyc, rise_cyc, first_recv, bv_first;

    task automatic mon_clear();
        acc_cyc = -1; cs_len = 0; nrecv = 0; nsend = 0; nen = 0; multi = 0;
        last_recv = -1; rmin = BIG; rmax = -1; last_en = -1; emin = BIG; emax = -1;
        fall_cyc = -1; rise_cyc = -1; first_recv = -1; bv_first = -1;
    endtask

    initial mon_clear();

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!resetn) mon_clear();
        else begin
            if (awvalid && wvalid && awready && wready) acc_cyc = cyc;
            if (!spi_cs_n) begin
                cs_len++;
                if (fall_cyc < 0) fall_cyc = cyc;
            end else if (fall_cyc >= 0 && rise_cyc < 0) rise_cyc = cyc;
            if (recv && send) multi++;
            if (recv) begin
                nrecv++;
                if (first_recv < 0) first_recv = cyc;
                if (last_recv >= 0) begin
                    if (cyc - last_recv < rmin) rmin = cyc - last_recv;
                    if (cyc - last_recv > rmax) rmax = cyc - last_recv;
                end
                last_recv = cyc;
            end
            if (send) nsend++;
            if (spi_clk_en) begin
                nen++;
                if (last_en >= 0) begin
                    if (cyc - last_en < emin) emin = cyc - last_en;
                    if (cyc - last_en > emax) emax = cyc - last_en;
                end
                last_en = cyc;
            end
            if (bvalid && bv_first < 0) bv_first = cyc;
            if (bvalid && bready) begin
                if (sb.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("bresp", int'(bresp), e.bresp);
                    chk("cs_low_len", cs_len, e.cs_len);
                    chk("recv_count", nrecv, e.nrecv);
                    chk("send_count", nsend, e.nsend);
                    chk("clk_en_count", nen, e.nen);
                    chk("recv_gap_min", (rmax < 0) ? -1 : rmin, e.rgap);
                    chk("recv_gap_max", rmax, e.rgap);
                    chk("en_gap_min", (emax < 0) ? -1 : emin, e.egap_min);
                    chk("en_gap_max", emax, e.egap_max);
                    chk("cs_fall_latency", (fall_cyc < 0) ? -1 : fall_cyc - acc_cyc, e.lat_cs);
                    chk("first_recv_latency", (first_recv < 0) ? -1 : first_recv - acc_cyc, e.lat_recv);
                    chk("bvalid_at_cs_rise", (rise_cyc < 0) ? -1 : bv_first - rise_cyc, e.resp_vs_rise);
                    chk("strobe_overlap", multi, 0);
                end
                mon_clear();
            end
        end
    end

    task automatic send_cmd(input logic [31:0] a, input logic [31:0] wd, input bit push);
        @(posedge clk); #1;
        if (push) sb.push_back(model(a, wd));
        awaddr = a; wdata = wd; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 500 && !(awready && wready); i++) @(posedge clk) #1;
        if (!(awready && wready)) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && (sb.size() != 0 || busy); i++) @(posedge clk) #1;
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        int bad;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_cs_n", spi_cs_n, 1);
        chk("rst_spi_clk", spi_clk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bvalid", bvalid, 0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("idle_awready", awready, 1);
        chk("idle_wready", wready, 1);
        chk("idle_cs_n", spi_cs_n, 1);
        chk("idle_bvalid", bvalid, 0);

        send_cmd(32'h0, 32'h0000_0200, 1'b1);
        wait_idle();
        send_cmd(32'h0, 32'h0000_0003, 1'b1);
        wait_idle();
        send_cmd(32'h4, 32'h0000_0200, 1'b1);
        wait_idle();
        send_cmd(32'h0, 32'h0000_0105, 1'b1);
        wait_idle();

        // address without data, then data; response stalled while a new command waits
        @(posedge clk); #1;
        sb.push_back(model(32'h0, 32'h0000_0100));
        awaddr = 32'h0; wdata = 32'h0000_0100; awvalid = 1'b1; wvalid = 1'b0; bready = 1'b0;
        repeat (5) @(posedge clk);
        #1 chk("aw_only_no_accept", busy, 0);
        wvalid = 1'b1;
        @(posedge clk); #1;
        chk("accept_both_valid", busy, 1);
        for (int i = 0; i < 500 && !bvalid; i++) @(posedge clk) #1;
        chk("bvalid_seen", bvalid, 1);
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (!bvalid || awready || wready) bad++;
        end
        chk("bvalid_hold_backpressure", bad, 0);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        wait_idle();

        // abort mid-byte, then a fresh command
        send_cmd(32'h0, 32'h0000_0301, 1'b0);
        repeat (20) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        chk("abort_cs_n", spi_cs_n, 1);
        chk("abort_spi_clk", spi_clk, 0);
        chk("abort_send", send, 0);
        chk("abort_bvalid", bvalid, 0);
        resetn = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bvalid || busy) bad++;
        end
        chk("abort_no_resp", bad, 0);
        send_cmd(32'h0, 32'h0000_0301, 1'b1);
        wait_idle();

`ifdef SPI_MASTER_CTRL_CPOL_EN
        send_cmd(32'h0, 32'h0001_0301, 1'b0);
        repeat (20) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk); #1;
        chk("cpol_abort_cs_n", spi_cs_n, 1);
        resetn = 1'b1;
        send_cmd(32'h0, 32'h0001_0301, 1'b1);
        chk("cpol_setup_idle_high", spi_clk, 1);
        wait_idle();
        chk("cpol_idle_high", spi_clk, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
